uart_cmd_parser: RTL
====================

Name: uart_cmd_parser

Overview:
- Consumes the byte stream from the UART byte receiver (`data_byte` / `rx_done` pulse) and assembles fixed-length 5-byte command frames.
- A valid frame produces a single-cycle register-write strobe with an 8-bit address and 16-bit data.
- Malformed or stalled frames are dropped and flagged with an error pulse and code.
- Sits directly downstream of the UART receive stage; feeds the board register file.

Parameters:
- HEADER, 8'hAA, start-of-frame byte.
- TIMEOUT_CYC, 100000, idle clock cycles allowed between bytes inside a frame. Range 1 to 2^20-1.

Ports:
- clk  input  1  system clock (50 MHz)
- rst_n  input  1  asynchronous active-low reset
- data_byte  input  8  received byte; valid only in the cycle `rx_done`=1
- rx_done  input  1  one-cycle pulse: `data_byte` valid
- wr_en  output  1  one-cycle pulse: good frame decoded
- wr_addr  output  8  decoded address; holds until next good frame
- wr_data  output  16  decoded data {hi,lo}; holds until next good frame
- frame_err  output  1  one-cycle pulse: frame aborted
- err_code  output  2  01 = checksum mismatch, 10 = timeout; holds until next error
- busy  output  1  1 while a frame is in progress (state != IDLE)

Behaviour:
- Reset: one clock; reset is asynchronous and active-low, on `rst_n`.
  - State = IDLE.
  - `wr_en` = 0, `wr_addr` = 0, `wr_data` = 0, `frame_err` = 0, `err_code` = 0, `busy` = 0.
  - Timeout counter = 0, checksum accumulator = 0.
  - Reset mid-frame discards the partial frame with no strobe and no error pulse.
- Frame format: HEADER, ADDR, DHI, DLO, CSUM.
  - CSUM = (ADDR + DHI + DLO) mod 256.
  - HEADER is not included in the checksum.
- FSM states and transitions (each advance happens only on `rx_done`=1):
  - IDLE: byte == HEADER → ADDR; clear accumulator. Any other byte is silently discarded: no error, stay in IDLE.
  - ADDR: latch into shadow addr; acc += byte → DHI.
  - DHI: latch shadow hi; acc += byte → DLO.
  - DLO: latch shadow lo; acc += byte → CSUM.
  - CSUM, byte == acc: → IDLE. Next cycle: `wr_en`=1, and `wr_addr`/`wr_data` update from shadows in that same cycle.
  - CSUM, byte != acc: → IDLE. Next cycle: `frame_err`=1, `err_code`=01. `wr_addr`/`wr_data` unchanged.
- Latency: `wr_en` / `frame_err` are registered and rise exactly 1 clk after the CSUM `rx_done` cycle.
- No resync: a HEADER value arriving in ADDR/DHI/DLO/CSUM is treated as ordinary data.
- Timeout: 20-bit counter.
  - Cleared in IDLE and on every `rx_done`.
  - Otherwise increments each clk while not in IDLE.
  - When the counter reaches TIMEOUT_CYC: → IDLE, `frame_err` pulses next cycle with `err_code`=10, counter cleared.
- Simultaneous events:
  - `rx_done` in the same cycle the counter would hit TIMEOUT_CYC: the byte wins, it is processed normally and the counter clears.
  - `wr_en` and `frame_err` are never both 1 in the same cycle.
- `busy` = registered (state != IDLE). It rises 1 clk after the header's `rx_done` and falls the same cycle `wr_en` / `frame_err` pulses.
- Back-to-back frames (next HEADER arriving one byte time after CSUM) are fully supported; no dead time is required.
- All arithmetic is 8-bit wrap-around. No FIFO: the upstream receiver guarantees at most one byte per `rx_done` pulse, with pulses ≥ 2 clks apart.

Test Plan:
1. Good frame: bytes AA 12 34 56 9C (driven by the TX → RX loopback at baud_set=0) → one `wr_en` pulse; `wr_addr`=8'h12, `wr_data`=16'h3456; `frame_err` never asserted; `busy` low afterwards.
2. Bad checksum: AA 12 34 56 9D → `frame_err` pulse with `err_code`=01; no `wr_en`; `wr_addr`/`wr_data` keep their values from test 1.
3. Timeout with TIMEOUT_CYC=1000, direct `rx_done` drive:
   - Send AA 01, then stall → `frame_err` with `err_code`=10 exactly 1000 clks after the 01 `rx_done`, plus 1.
   - Then AA 01 00 05 06 → `wr_en` with `wr_addr`=01, `wr_data`=0005.
4. Garbage and embedded header:
   - Bytes 00 FF 55 → no outputs; `busy` stays 0.
   - Then AA AA AA AA 54 (AA+AA+AA = 0x1FE, i.e. 0xFE mod 256; 54 != FE) → `err_code`=01.
   - Then AA AA AA AA FE → `wr_en` with `wr_addr`=AA, `wr_data`=AAAA.
5. Reset mid-frame: send AA 12, then pulse `rst_n` low for 3 clks → all outputs 0. Then a full valid frame AA 07 00 01 08 → `wr_en` with `wr_addr`=07, `wr_data`=0001.
6. Back-to-back frames: AA 01 00 02 03 immediately followed by AA 02 00 03 05 → two `wr_en` pulses, capturing (01,0002) then (02,0003); no errors.

Source files
------------

// File: rtl/uart_cmd_parser.sv
// UART command-frame parser: turns HEADER/ADDR/DHI/DLO/CSUM byte frames into
// single-cycle register-write strobes; bad-checksum or stalled frames raise an error pulse.
module uart_cmd_parser #(
    parameter logic [7:0]  HEADER      = 8'hAA,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  data_byte,
    input  logic        rx_done,
    output logic        wr_en,
    output logic [7:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        frame_err,
    output logic [1:0]  err_code,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DHI,
        S_DLO,
        S_CSUM
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_CSUM    = 2'b01,
        ERR_TIMEOUT = 2'b10
    } err_t;

    localparam logic [19:0] TMO_LIMIT = 20'(TIMEOUT_CYC);

    state_t      state_q,     state_d;
    logic [7:0]  acc_q,       acc_d;
    logic [7:0]  addr_sh_q,   addr_sh_d;
    logic [7:0]  hi_sh_q,     hi_sh_d;
    logic [7:0]  lo_sh_q,     lo_sh_d;
    logic [19:0] tmo_cnt_q,   tmo_cnt_d;
    logic        wr_en_q,     wr_en_d;
    logic [7:0]  wr_addr_q,   wr_addr_d;
    logic [15:0] wr_data_q,   wr_data_d;
    logic        frame_err_q, frame_err_d;
    err_t        err_code_q,  err_code_d;
    logic        busy_q,      busy_d;

    always_comb begin
        // NOTE: every signal gets its default before the case so no path leaves
        // one unassigned; a missing default here would infer a latch.
        state_d     = state_q;
        acc_d       = acc_q;
        addr_sh_d   = addr_sh_q;
        hi_sh_d     = hi_sh_q;
        lo_sh_d     = lo_sh_q;
        tmo_cnt_d   = tmo_cnt_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_err_d = 1'b0;
        err_code_d  = err_code_q;

        case (state_q)
            S_IDLE: begin
                if (rx_done && (data_byte == HEADER)) begin
                    state_d = S_ADDR;
                    acc_d   = '0;
                end
            end
            S_ADDR: begin
                if (rx_done) begin
                    addr_sh_d = data_byte;
                    acc_d     = acc_q + data_byte;
                    state_d   = S_DHI;
                end
            end
            S_DHI: begin
                if (rx_done) begin
                    hi_sh_d = data_byte;
                    acc_d   = acc_q + data_byte;
                    state_d = S_DLO;
                end
            end
            S_DLO: begin
                if (rx_done) begin
                    lo_sh_d = data_byte;
                    acc_d   = acc_q + data_byte;
                    state_d = S_CSUM;
                end
            end
            S_CSUM: begin
                if (rx_done) begin
                    state_d = S_IDLE;
                    if (data_byte == acc_q) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_sh_q;
                        wr_data_d = {hi_sh_q, lo_sh_q};
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_CSUM;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A byte arriving on the limit cycle wins over the timeout.
        if ((state_q == S_IDLE) || rx_done) begin
            tmo_cnt_d = '0;
        end else if (tmo_cnt_q >= TMO_LIMIT) begin
            tmo_cnt_d   = '0;
            state_d     = S_IDLE;
            frame_err_d = 1'b1;
            err_code_d  = ERR_TIMEOUT;
        end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end

        busy_d = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, independent of statement order.
    // The small shadow/accumulator registers are reset along with the rest so a
    // mid-frame reset leaves nothing stale behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            addr_sh_q   <= '0;
            hi_sh_q     <= '0;
            lo_sh_q     <= '0;
            tmo_cnt_q   <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            frame_err_q <= 1'b0;
            err_code_q  <= ERR_NONE;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            addr_sh_q   <= addr_sh_d;
            hi_sh_q     <= hi_sh_d;
            lo_sh_q     <= lo_sh_d;
            tmo_cnt_q   <= tmo_cnt_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
            busy_q      <= busy_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign frame_err = frame_err_q;
    assign err_code  = err_code_q;
    assign busy      = busy_q;

endmodule
